adc_sample_fifo: RTL and testbench

Sample buffer directly downstream of `wrapper_control`: captures each ADC conversion result when `fifo_write_en` pulses, reports `fifo_full` back to the controller, and exposes buffered samples to the CPU through an APB3 slave. Samples are popped by APB reads of the DATA register. Overflow is recorded in a sticky flag rather than stalling acquisition.

---
 rtl/adc_fifo_pkg.sv | 29 ++
 rtl/adc_fifo_core.sv | 96 +++++++++
 rtl/adc_sample_fifo.sv | 147 ++++++++++++++
 tb/tb_adc_sample_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_fifo_pkg.sv
// adc_fifo_pkg: shared definitions for the ADC sample FIFO.
//   - register selector (paddr[3:2]) and byte offsets of DATA/STATUS/CTRL/THRESH
//   - STATUS and CTRL bit positions
//   - default sample width
package adc_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_W = 12;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_sel_e;

  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;
  localparam logic [3:0] OFS_THRESH = 4'hC;

  localparam int unsigned STAT_COUNT_LSB   = 0;
  localparam int unsigned STAT_EMPTY_BIT   = 8;
  localparam int unsigned STAT_FULL_BIT    = 9;
  localparam int unsigned STAT_OVF_BIT     = 10;

  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_CLR_OVF_BIT = 1;

endpackage

// File: rtl/adc_fifo_core.sv
// adc_fifo_core: circular sample store with pointers, occupancy count and
// registered full / not-empty flags.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     push request and sample
//   pop               pop request (ignored when empty)
//   flush             clear pointers and count; a concurrent push is discarded
//   rd_data           head entry, combinational
//   count             occupancy, $clog2(DEPTH)+1 bits
//   full, not_empty   flags registered from the next count
//   dropped           push refused because the FIFO was full and nothing popped
module adc_fifo_core
  import adc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              not_empty,
  output logic              dropped
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              not_empty_q, not_empty_d;
  logic              at_depth;
  logic              pop_ok;
  logic              push_ok;

  assign at_depth = (count_q == CW'(DEPTH));
  assign pop_ok   = pop && (count_q != '0) && !flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok  = push && !flush && (!at_depth || pop_ok);
  assign dropped  = push && !flush && at_depth && !pop_ok;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d      = (count_d == CW'(DEPTH));
    not_empty_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      not_empty_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      not_empty_q <= not_empty_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data   = mem_q[rptr_q];
  assign count     = count_q;
  assign full      = full_q;
  assign not_empty = not_empty_q;

endmodule

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: ADC sample buffer with APB3 slave access.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   wr_en, wr_data           sample push from the acquisition controller
//   fifo_full                count == DEPTH (registered)
//   fifo_not_empty           count != 0 (registered)
//   psel..pwdata             APB3 request; paddr[1:0] ignored
//   prdata, pready, pslverr  APB3 response, zero wait states
//   irq                      level interrupt, present when ADC_FIFO_IRQ_EN is
//                            defined, otherwise tied 0
// Registers: 0x0 DATA (RO, pop), 0x4 STATUS (RO), 0x8 CTRL (WO), 0xC THRESH (RW).
module adc_sample_fifo
  import adc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned THRESH_RST = 8,
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              fifo_full,
  output logic              fifo_not_empty,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [3:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq
);

  logic [DATA_W-1:0] rd_data;
  logic [CW-1:0]     count;
  logic              full;
  logic              not_empty;
  logic              dropped;
  logic              rd_acc;
  logic              wr_acc;
  reg_sel_e          sel;
  logic              pop;
  logic              flush;
  logic              clr_ovf;
  logic              err;
  logic [31:0]       rdata;
  logic [31:0]       status_w;
  logic              overflow_q, overflow_d;
  logic [7:0]        thresh_q, thresh_d;
  logic              unused_bits;

  assign unused_bits = ^{paddr[1:0], pwdata[31:8]};

  assign rd_acc = psel && penable && !pwrite;
  assign wr_acc = psel && penable && pwrite;
  assign sel    = reg_sel_e'(paddr[3:2]);

  assign pop     = rd_acc && (sel == REG_DATA) && not_empty;
  assign flush   = wr_acc && (sel == REG_CTRL) && pwdata[CTRL_FLUSH_BIT];
  assign clr_ovf = wr_acc && (sel == REG_CTRL) && pwdata[CTRL_CLR_OVF_BIT];

  adc_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst),
    .push      (wr_en),
    .wr_data   (wr_data),
    .pop       (pop),
    .flush     (flush),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full),
    .not_empty (not_empty),
    .dropped   (dropped)
  );

  always_comb begin
    status_w                 = '0;
    status_w[STAT_COUNT_LSB +: 8] = 8'(count);
    status_w[STAT_EMPTY_BIT] = !not_empty;
    status_w[STAT_FULL_BIT]  = full;
    status_w[STAT_OVF_BIT]   = overflow_q;
  end

  always_comb begin
    err   = 1'b0;
    rdata = '0;
    if (rd_acc) begin
      unique case (sel)
        REG_DATA:   begin err = !not_empty; rdata = not_empty ? 32'(rd_data) : '0; end
        REG_STATUS: rdata = status_w;
        REG_THRESH: rdata = {24'd0, thresh_q};
        default:    err = 1'b1;
      endcase
    end else if (wr_acc) begin
      err = !((sel == REG_CTRL) || (sel == REG_THRESH));
    end
  end

  // Response is forced to its reset value while rst is held, independent of the bus.
  assign prdata  = rst ? rdata : '0;
  assign pslverr = rst ? err : 1'b0;
  assign pready  = 1'b1;

  always_comb begin
    overflow_d = overflow_q;
    thresh_d   = thresh_q;
    // Set takes priority over a clear in the same cycle.
    if (dropped)      overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
    if (wr_acc && (sel == REG_THRESH)) thresh_d = pwdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      thresh_q   <= 8'(THRESH_RST);
    end else begin
      overflow_q <= overflow_d;
      thresh_q   <= thresh_d;
    end
  end

  assign fifo_full      = full;
  assign fifo_not_empty = not_empty;

`ifdef ADC_FIFO_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = ((32'(count) >= 32'(thresh_q)) && (thresh_q != '0)) || overflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sample_fifo.sv
module tb_adc_sample_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 12;
  localparam int unsigned TRST  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          fifo_full;
  logic          fifo_not_empty;
  logic          psel, penable, pwrite;
  logic [3:0]    paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic          irq;

  adc_sample_fifo #(
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .THRESH_RST (TRST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .fifo_full      (fifo_full),
    .fifo_not_empty (fifo_not_empty),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int unsigned q[$];
  bit          ovf;
  int unsigned thr;
  bit          irq_m;
  logic [31:0] last_rd;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf   = 1'b0;
    thr   = TRST;
    irq_m = 1'b0;
  endtask

  // One clock: called at posedge+1, drives inputs, checks the combinational
  // response at the negedge, advances the model, checks flags at posedge+1.
  task automatic cyc(input bit wr, input int unsigned wd, input bit sel, input bit en,
                     input bit wrt, input logic [3:0] a, input logic [31:0] wdat);
    int unsigned r, n;
    bit          acc, pop, err, flush, clr, ovf_set;
    logic [31:0] exp_rd;
    wr_en   = wr;
    wr_data = DW'(wd);
    psel    = sel;
    penable = en;
    pwrite  = wrt;
    paddr   = a;
    pwdata  = wdat;
    @(negedge clk);
    r   = int'(a[3:2]);
    n   = q.size();
    acc = sel && en;
    pop = acc && !wrt && r == 0 && n > 0;
    err = acc && (wrt ? (r < 2) : (r == 2 || (r == 0 && n == 0)));
    exp_rd = '0;
    if (acc && !wrt && !err) begin
      case (r)
        0: exp_rd = q[0];
        1: exp_rd = {21'd0, ovf, (n == DEPTH), (n == 0), 8'(n)};
        3: exp_rd = thr;
        default: exp_rd = '0;
      endcase
    end
    check("pslverr", 32'(pslverr), 32'(err));
    if (acc) begin
      check("prdata", prdata, exp_rd);
      last_rd  = prdata;
      last_err = pslverr;
    end
    flush = acc && wrt && r == 2 && wdat[0];
    clr   = acc && wrt && r == 2 && wdat[1];
`ifdef ADC_FIFO_IRQ_EN
    irq_m = (thr != 0 && n >= thr) || ovf;
`else
    irq_m = 1'b0;
`endif
    ovf_set = 1'b0;
    if (pop) void'(q.pop_front());
    if (flush) q.delete();
    else if (wr) begin
      if (n < DEPTH || pop) q.push_back(wd);
      else ovf_set = 1'b1;
    end
    if (ovf_set) ovf = 1'b1;
    else if (clr) ovf = 1'b0;
    if (acc && wrt && r == 3) thr = int'(wdat[7:0]);
    @(posedge clk);
    #1;
    check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    check("fifo_not_empty", 32'(fifo_not_empty), 32'(q.size() != 0));
    check("irq", 32'(irq), 32'(irq_m));
    check("pready", 32'(pready), 32'd1);
  endtask

  task automatic push(input int unsigned d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 4'h0, '0);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 4'h0, '0);
  endtask

  task automatic apb_rd(input logic [3:0] a, input bit wr, input int unsigned wd);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, a, '0);
    cyc(wr, wd, 1'b1, 1'b1, 1'b0, a, '0);
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d, input bit wr, input int unsigned wd);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, a, d);
    cyc(wr, wd, 1'b1, 1'b1, 1'b1, a, d);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    last_rd = '0; last_err = 1'b0;
    model_reset();
    #1;
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_not_empty", 32'(fifo_not_empty), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pready", 32'(pready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic push / pop / underflow
    apb_rd(4'hC, 1'b0, 0);
    check("thresh_rst", last_rd, 32'(TRST));
    push(12'h123);
    push(12'h456);
    apb_rd(4'h4, 1'b0, 0);
    check("plan_count2", last_rd & 32'hFF, 32'd2);
    apb_rd(4'h0, 1'b0, 0);
    check("plan_rd1", last_rd, 32'h123);
    apb_rd(4'h0, 1'b0, 0);
    check("plan_rd2", last_rd, 32'h456);
    apb_rd(4'h0, 1'b0, 0);
    check("plan_underflow_err", 32'(last_err), 32'd1);
    check("plan_underflow_data", last_rd, 32'd0);

    // Fill, overflow, clear overflow
    for (int i = 0; i < 16; i++) push(32'h100 + i);
    check("plan_full", 32'(fifo_full), 32'd1);
    push(12'hABC);
    apb_rd(4'h4, 1'b0, 0);
    check("plan_ovf_set", 32'(last_rd[10]), 32'd1);
    apb_wr(4'h8, 32'h2, 1'b0, 0);
    apb_rd(4'h4, 1'b0, 0);
    check("plan_ovf_clr", 32'(last_rd[10]), 32'd0);

    // Full with concurrent push and pop, across the pointer wrap
    for (int i = 0; i < 20; i++) apb_rd(4'h0, 1'b1, 32'h200 + i);
    apb_rd(4'h4, 1'b0, 0);
    check("plan_full_pp_count", last_rd & 32'h7FF, 32'h210);

    // Flush with concurrent push
    apb_wr(4'h8, 32'h1, 1'b0, 0);
    for (int i = 0; i < 5; i++) push(32'h300 + i);
    apb_wr(4'h8, 32'h1, 1'b1, 12'h777);
    check("plan_flush_ne", 32'(fifo_not_empty), 32'd0);
    apb_rd(4'h0, 1'b0, 0);
    check("plan_flush_err", 32'(last_err), 32'd1);

    // Pop and push together while empty: push lands, pop errors
    apb_rd(4'h0, 1'b1, 12'h5A5);
    check("empty_pp_err", 32'(last_err), 32'd1);
    apb_rd(4'h0, 1'b0, 0);
    check("empty_pp_data", last_rd, 32'h5A5);

`ifdef ADC_FIFO_IRQ_EN
    apb_wr(4'hC, 32'h4, 1'b0, 0);
    for (int i = 0; i < 4; i++) push(32'h40 + i);
    idle();
    check("plan_irq_on", 32'(irq), 32'd1);
    apb_rd(4'h0, 1'b0, 0);
    idle();
    check("plan_irq_off", 32'(irq), 32'd0);
    apb_wr(4'h8, 32'h1, 1'b0, 0);
    apb_wr(4'hC, 32'(TRST), 1'b0, 0);
`endif

    // Asynchronous reset in the middle of a burst
    apb_wr(4'h8, 32'h1, 1'b0, 0);
    for (int i = 0; i < 7; i++) push(32'h60 + i);
    wr_en = 1'b1; wr_data = 12'hFFF;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 4'h0;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_full", 32'(fifo_full), 32'd0);
    check("mid_rst_ne", 32'(fifo_not_empty), 32'd0);
    check("mid_rst_prdata", prdata, 32'd0);
    check("mid_rst_pslverr", 32'(pslverr), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_pready", 32'(pready), 32'd1);
    wr_en = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    apb_rd(4'h4, 1'b0, 0);
    check("mid_rst_count", last_rd & 32'hFF, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int unsigned k, d;
      k = $urandom_range(0, 9);
      d = $urandom_range(0, 4095);
      case (k)
        0, 1, 2: push(d);
        3, 4, 5: apb_rd(4'h0, 1'($urandom_range(0, 1)), d);
        6:       apb_rd(4'(4 + $urandom_range(0, 3)), 1'($urandom_range(0, 1)), d);
        7: begin
          logic [31:0] c;
          c = 32'($urandom_range(0, 1)) << 1;
          if ($urandom_range(0, 7) == 0) c[0] = 1'b1;
          apb_wr(4'h8, c, 1'($urandom_range(0, 1)), d);
        end
        8:       apb_wr(4'(12 + $urandom_range(0, 3)), 32'($urandom_range(0, 20)), 1'b0, 0);
        default: begin
          if ($urandom_range(0, 1) == 1) apb_rd(4'(8 + $urandom_range(0, 3)), 1'b1, d);
          else apb_wr(4'($urandom_range(0, 7)), $urandom, 1'b1, d);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
